// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser, per-channel debounce FSM, and
// registered level / press / release / long-press outputs for downstream FSMs.
module button_conditioner #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int CNT_WIDTH       = 25
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    output logic [NUM_BUTTONS-1:0] button_level,
    output logic [NUM_BUTTONS-1:0] button_press,
    output logic [NUM_BUTTONS-1:0] button_release,
    output logic [NUM_BUTTONS-1:0] button_long
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    state_t                 r_state [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   r_cnt   [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0]   r_hold  [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] r_long_done;
    logic [NUM_BUTTONS-1:0] r_level;
    logic [NUM_BUTTONS-1:0] r_press;
    logic [NUM_BUTTONS-1:0] r_release;
    logic [NUM_BUTTONS-1:0] r_long;

    // The FSM only ever looks at r_sync2; r_sync1 may go metastable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                r_state[i] <= STABLE_LOW;
                r_cnt[i]   <= '0;
                r_hold[i]  <= '0;
            end
            r_long_done <= '0;
            r_level     <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_long      <= '0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                case (r_state[i])
                    STABLE_LOW: begin
                        r_level[i] <= 1'b0;
                        if (r_sync2[i]) begin
                            r_state[i] <= WAIT_HIGH;
                            r_cnt[i]   <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= STABLE_LOW;
                        end else if (r_cnt[i] == DEB_LAST) begin
                            r_state[i]     <= STABLE_HIGH;
                            r_level[i]     <= 1'b1;
                            r_press[i]     <= 1'b1;
                            r_hold[i]      <= '0;
                            r_long_done[i] <= 1'b0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                        end
                    end
                    STABLE_HIGH: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= WAIT_LOW;
                            r_cnt[i]   <= '0;
                        end else if (!r_long_done[i]) begin
                            if (r_hold[i] == LONG_LAST) begin
                                r_long[i]      <= 1'b1;
                                r_long_done[i] <= 1'b1;
                            end else begin
                                r_hold[i] <= r_hold[i] + CNT_WIDTH'(1);
                            end
                        end
                    end
                    WAIT_LOW: begin
                        // A bounce back to high resumes the same press: hold and long_done are kept.
                        if (r_sync2[i]) begin
                            r_state[i] <= STABLE_HIGH;
                        end else if (r_cnt[i] == DEB_LAST) begin
                            r_state[i]   <= STABLE_LOW;
                            r_level[i]   <= 1'b0;
                            r_release[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= STABLE_LOW;
                        r_level[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign button_level   = r_level;
    assign button_press   = r_press;
    assign button_release = r_release;
    assign button_long    = r_long;

endmodule
